// File: rtl/mod_sseg_mux_pkg.sv
// Shared definitions for the multiplexed seven-segment controller:
// register map, CTRL field layout, reset value and the hex font.
package mod_sseg_mux_pkg;

    typedef enum logic [1:0] {
        REG_DATA0  = 2'd0,
        REG_DATA1  = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    typedef enum logic {
        MODE_RAW = 1'b0,
        MODE_HEX = 1'b1
    } disp_mode_e;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_MODE_BIT   = 1;
    localparam int unsigned CTRL_BRIGHT_LSB = 4;
    localparam int unsigned CTRL_BRIGHT_W   = 4;
    localparam int unsigned CTRL_DP_LSB     = 8;
    localparam int unsigned CTRL_DP_W       = 8;
    localparam int unsigned CTRL_BLANK_LSB  = 16;
    localparam int unsigned CTRL_BLANK_W    = 8;

    // Bits outside the defined CTRL fields are never stored, so they read 0.
    localparam logic [31:0] CTRL_WRITE_MASK = 32'h00FF_FFF3;
    localparam logic [31:0] CTRL_RESET      = 32'h0000_00F1;

    // Active-low {g,f,e,d,c,b,a} for 0-F.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/mod_sseg_mux_if.sv
// PLP data-bus slice seen by the seven-segment controller.
interface mod_sseg_mux_if;

    logic        ie;
    logic        de;
    logic        drw;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] din;
    logic [31:0] iout;
    logic [31:0] dout;

    modport master (
        output ie, de, drw, iaddr, daddr, din,
        input  iout, dout
    );

    modport slave (
        input  ie, de, drw, iaddr, daddr, din,
        output iout, dout
    );

endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module sseg_hex_decode
    import mod_sseg_mux_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/mod_sseg_mux.sv
// Memory-mapped multi-digit seven-segment scanner with raw/hex modes,
// per-digit blank and dp masks, and 16-level PWM brightness.
module mod_sseg_mux
    import mod_sseg_mux_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 25000000,
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned REFRESH_HZ = 60
) (
    input  logic              clk,
    input  logic              rst,
    mod_sseg_mux_if.slave     bus,
    output logic [DIGITS-1:0] sseg_an,
    output logic [7:0]        sseg_display
);

    localparam int unsigned TICKS     = CLOCK_FREQ / (REFRESH_HZ * DIGITS);
    localparam int unsigned PHASE_DIV = TICKS / 16;
    localparam int unsigned SUB_W     = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    logic [31:0]       data0_q, data0_d;
    logic [31:0]       data1_q, data1_d;
    logic [31:0]       ctrl_q, ctrl_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [3:0]        phase_q, phase_d;
    logic [2:0]        idx_q, idx_d;
    logic              frame_q, frame_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        disp_q, disp_d;

    reg_sel_e   sel;
    logic       en;
    disp_mode_e mode;
    logic [3:0] bright;
    logic [7:0] dp_mask;
    logic [7:0] blank_mask;
    logic [63:0] raw_bytes;
    logic [7:0]  raw_byte;
    logic [3:0]  nibble;
    logic [6:0]  hex_seg;
    logic [7:0]  pattern;
    logic        lit;
    logic        unused_bus;

    assign sel        = reg_sel_e'(bus.daddr[3:2]);
    assign en         = ctrl_q[CTRL_EN_BIT];
    assign mode       = disp_mode_e'(ctrl_q[CTRL_MODE_BIT]);
    assign bright     = ctrl_q[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
    assign dp_mask    = ctrl_q[CTRL_DP_LSB +: CTRL_DP_W];
    assign blank_mask = ctrl_q[CTRL_BLANK_LSB +: CTRL_BLANK_W];
    assign unused_bus = ^{bus.ie, bus.iaddr, bus.daddr[31:4], bus.daddr[1:0]};

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        ctrl_d  = ctrl_q;
        if (bus.de && bus.drw) begin
            unique case (sel)
                REG_DATA0:  data0_d = bus.din;
                REG_DATA1:  data1_d = bus.din;
                REG_CTRL:   ctrl_d  = bus.din & CTRL_WRITE_MASK;
                REG_STATUS: ;
                default:    ;
            endcase
        end
    end

    // Slot counter is split into (phase, sub-phase): phase = slot / (TICKS/16)
    // falls out directly and the slot wraps when both reach their last value.
    always_comb begin
        sub_d   = sub_q + SUB_W'(1);
        phase_d = phase_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        if (sub_q == SUB_LAST) begin
            sub_d   = '0;
            phase_d = phase_q + 4'd1;
            if (phase_q == 4'hF) begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    frame_d = ~frame_q;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end
    end

    assign raw_bytes = {data1_q, data0_q};
    assign raw_byte  = raw_bytes[{idx_q, 3'b000} +: 8];
    assign nibble    = data0_q[{idx_q, 2'b00} +: 4];

    sseg_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        lit     = en && !blank_mask[idx_q] && (phase_q <= bright);
        pattern = (mode == MODE_HEX) ? {~dp_mask[idx_q], hex_seg} : raw_byte;
        an_d    = lit ? ~(DIGITS'(1) << idx_q) : '1;
        disp_d  = lit ? pattern : 8'hFF;
    end

    always_comb begin
        bus.dout = '0;
        unique case (sel)
            REG_DATA0:  bus.dout = data0_q;
            REG_DATA1:  bus.dout = data1_q;
            REG_CTRL:   bus.dout = ctrl_q;
            REG_STATUS: bus.dout = {23'b0, frame_q, 5'b0, idx_q};
            default:    bus.dout = '0;
        endcase
    end

    assign bus.iout = '0;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            data0_q <= '0;
            data1_q <= '0;
            ctrl_q  <= CTRL_RESET;
            sub_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            frame_q <= 1'b0;
            an_q    <= '1;
            disp_q  <= 8'hFF;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            ctrl_q  <= ctrl_d;
            sub_q   <= sub_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            disp_q  <= disp_d;
        end
    end

    assign sseg_an      = an_q;
    assign sseg_display = disp_q;

endmodule

// File: tb/tb_mod_sseg_mux.sv
// Randomised bench for mod_sseg_mux against a cycle-count reference model,
// plus directed scan, hex, PWM, blank and reset scenarios.
module tb_mod_sseg_mux;

    localparam int unsigned CF    = 25600;
    localparam int unsigned RH    = 100;
    localparam int unsigned ND    = 4;
    localparam int unsigned TICKS = CF / (RH * ND);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] an;
    logic [7:0] disp;
    logic       chk_on = 1'b0;

    mod_sseg_mux_if bus ();

    mod_sseg_mux #(
        .CLOCK_FREQ (CF),
        .DIGITS     (ND),
        .REFRESH_HZ (RH)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .bus          (bus),
        .sseg_an      (an),
        .sseg_display (disp)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: everything derives from the number of clocks since reset.
    logic [31:0] m_data0, m_data1, m_ctrl;
    int unsigned m_cnt;
    logic [3:0]  exp_an;
    logic [7:0]  exp_disp;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [11:0] model_out(input int unsigned cnt, input logic [31:0] c,
                                              input logic [31:0] d0, input logic [31:0] d1);
        int unsigned slot, idx, phase;
        logic lit;
        logic [7:0] pat;
        slot  = cnt % TICKS;
        idx   = (cnt / TICKS) % ND;
        phase = slot / (TICKS / 16);
        lit   = c[0] && !c[16 + idx] && (phase <= int'(c[7:4]));
        if (c[1])       pat = {~c[8 + idx], font(d0[4*idx +: 4])};
        else if (idx < 4) pat = d0[8*idx +: 8];
        else            pat = d1[8*(idx-4) +: 8];
        return lit ? {~(4'b0001 << idx), pat} : 12'hFFF;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [1:0] a);
        logic [2:0] idx3;
        logic       fr;
        idx3 = 3'((m_cnt / TICKS) % ND);
        fr   = ((m_cnt / (TICKS * ND)) % 2) == 1;
        case (a)
            2'd0:    return m_data0;
            2'd1:    return m_data1;
            2'd2:    return m_ctrl;
            default: return {23'b0, fr, 5'b0, idx3};
        endcase
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data0  <= '0;
            m_data1  <= '0;
            m_ctrl   <= 32'h0000_00F1;
            m_cnt    <= 0;
            exp_an   <= 4'hF;
            exp_disp <= 8'hFF;
        end else begin
            {exp_an, exp_disp} <= model_out(m_cnt, m_ctrl, m_data0, m_data1);
            if (bus.de && bus.drw) begin
                case (bus.daddr[3:2])
                    2'd0:    m_data0 <= bus.din;
                    2'd1:    m_data1 <= bus.din;
                    2'd2:    m_ctrl  <= bus.din & 32'h00FF_FFF3;
                    default: ;
                endcase
            end
            m_cnt <= m_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (chk_on) begin
            check_eq("an", an, exp_an);
            check_eq("disp", disp, exp_disp);
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] ad;
        ad = $urandom;
        ad[3:2] = a;
        @(posedge clk);
        bus.de = 1'b1; bus.drw = 1'b1; bus.daddr = ad; bus.din = d;
        @(posedge clk);
        bus.de = 1'b0; bus.drw = 1'b0;
    endtask

    task automatic read_check(input logic [1:0] a, input string tag, output logic [31:0] got);
        logic [31:0] ad;
        ad = $urandom;
        ad[3:2] = a;
        @(posedge clk);
        bus.daddr = ad;
        #1;
        got = bus.dout;
        check_eq(tag, got, exp_reg(a));
    endtask

    logic [7:0] cap [4];

    task automatic capture_digits();
        for (int i = 0; i < 4; i++) cap[i] = 8'hFF;
        repeat (256) begin
            @(posedge clk);
            for (int d = 0; d < 4; d++)
                if (an == ~(4'b0001 << d)) cap[d] = disp;
        end
    endtask

    task automatic count_an(input logic [3:0] pat, output int unsigned n);
        n = 0;
        repeat (256) begin
            @(posedge clk);
            if (an == pat) n++;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_an", an, 4'hF);
        check_eq("rst_disp", disp, 8'hFF);
        bus.daddr = 32'h8;
        #1;
        check_eq("rst_ctrl", bus.dout, 32'h0000_00F1);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r, s1, s2;
        int unsigned n;
        bool_wait: begin end
        bus.ie = 1'b0; bus.de = 1'b0; bus.drw = 1'b0;
        bus.iaddr = '0; bus.daddr = '0; bus.din = '0;
        repeat (3) @(posedge clk);
        chk_on = 1'b1;
        read_check(2'd2, "reset_ctrl", r);
        check_eq("reset_ctrl_const", r, 32'h0000_00F1);
        read_check(2'd0, "reset_data0", r);
        check_eq("iout", bus.iout, 32'h0);
        @(posedge clk);
        rst_n = 1'b1;

        read_check(2'd3, "status_a", s1);
        repeat (255) @(posedge clk);
        read_check(2'd3, "status_b", s2);
        check_eq("frame_toggle", {31'b0, s1[8] ^ s2[8]}, 32'h1);

        bus_write(2'd0, 32'h1234_5678);
        read_check(2'd0, "data0_rb", r);
        check_eq("data0_const", r, 32'h1234_5678);
        capture_digits();
        check_eq("raw_d0", cap[0], 8'h78);
        check_eq("raw_d3", cap[3], 8'h12);

        bus_write(2'd2, 32'h0000_03F3);
        bus_write(2'd0, 32'h0000_A5C0);
        capture_digits();
        check_eq("hex_d0", cap[0], 8'h40);
        check_eq("hex_d1", cap[1], 8'h46);
        check_eq("hex_d2", cap[2], 8'h92);
        check_eq("hex_d3", cap[3], 8'h88);

        bus_write(2'd2, 32'h0000_0031);
        repeat (2) @(posedge clk);
        count_an(4'hF, n);
        check_eq("pwm3_dark", n, 192);
        count_an(4'b1110, n);
        check_eq("pwm3_d0", n, 16);

        bus_write(2'd2, 32'h0004_00F1);
        repeat (2) @(posedge clk);
        count_an(4'b1011, n);
        check_eq("blank_d2", n, 0);
        count_an(4'hF, n);
        check_eq("blank_dark", n, 64);

        read_check(2'd3, "status_pre", s1);
        bus_write(2'd3, 32'hFFFF_FFFF);
        read_check(2'd3, "status_wr", s2);

        repeat ($urandom_range(70, 10)) @(posedge clk);
        reset_pulse();
        begin
            int unsigned k;
            k = 0;
            while (an == 4'hF && k < 300) begin
                @(posedge clk);
                k++;
            end
            check_eq("first_lit", an, 4'b1110);
        end

        for (int it = 0; it < 60; it++) begin
            int unsigned op;
            logic [31:0] d;
            op = $urandom_range(9, 0);
            d  = $urandom;
            bus.ie = 1'($urandom); bus.iaddr = $urandom;
            if (op < 4) begin
                if (op == 2 && $urandom_range(1, 0) == 1) d[0] = 1'b1;
                bus_write(2'(op), d);
            end else if (op < 6) begin
                read_check(2'($urandom_range(3, 0)), "rand_read", r);
            end else if (op == 6) begin
                @(posedge clk);
                bus.de = 1'b1; bus.drw = 1'b0; bus.daddr = 32'h8; bus.din = d;
                @(posedge clk);
                bus.de = 1'b0;
                read_check(2'd2, "no_write_rd", r);
            end else if (op == 7 && it % 20 == 7) begin
                reset_pulse();
            end else begin
                repeat ($urandom_range(200, 1)) @(posedge clk);
            end
        end
        repeat (300) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
